// File: rtl/int_to_single_small.sv
// Multi-cycle 32-bit signed int to IEEE-754 single converter, one normalisation shift per clock.
// Optional macro INT_TO_SINGLE_ROUND_EN selects round-to-nearest-even in PACK; default build truncates.
module int_to_single_small (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] int_val,
    input  logic        int_cont,
    input  logic        single_cont,
    output logic [31:0] single_val,
    output logic        int_ready,
    output logic        single_ready
);

    typedef enum logic [2:0] {
        GETIN     = 3'd0,
        UNPACK    = 3'd1,
        SPECIAL   = 3'd2,
        NORMALISE = 3'd3,
        PACK      = 3'd4,
        PUTOUT    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic        a_s_q, a_s_d;
    logic [31:0] a_m_q, a_m_d;
    logic [7:0]  a_e_q, a_e_d;
    logic [31:0] z_q, z_d;
    logic [31:0] single_val_q, single_val_d;
    logic        int_ready_q, int_ready_d;
    logic        single_ready_q, single_ready_d;

    logic        round_inc;
    logic [30:0] pack_mag;

`ifdef INT_TO_SINGLE_ROUND_EN
    // guard = first dropped bit, sticky = OR of the rest, ties go to even
    assign round_inc = a_m_q[7] && ((|a_m_q[6:0]) || a_m_q[8]);
`else
    assign round_inc = 1'b0;
`endif

    // One add over {exponent, mantissa} lets a mantissa carry bump the exponent.
    assign pack_mag = {a_e_q + 8'd127, a_m_q[30:8]} + {30'd0, round_inc};

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        a_s_d          = a_s_q;
        a_m_d          = a_m_q;
        a_e_d          = a_e_q;
        z_d            = z_q;
        single_val_d   = single_val_q;
        int_ready_d    = int_ready_q;
        single_ready_d = single_ready_q;

        case (state_q)
            GETIN: begin
                int_ready_d = 1'b1;
                if (int_ready_q && int_cont) begin
                    a_d         = int_val;
                    int_ready_d = 1'b0;
                    state_d     = UNPACK;
                end
            end
            UNPACK: begin
                // 0x80000000 negates to itself, which is the correct magnitude
                a_s_d   = a_q[31];
                a_m_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
                a_e_d   = 8'd31;
                state_d = SPECIAL;
            end
            SPECIAL: begin
                if (a_m_q == 32'd0) begin
                    z_d     = 32'd0;
                    state_d = PUTOUT;
                end else begin
                    state_d = NORMALISE;
                end
            end
            NORMALISE: begin
                if (!a_m_q[31]) begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - 8'd1;
                end else begin
                    state_d = PACK;
                end
            end
            PACK: begin
                z_d     = {a_s_q, pack_mag};
                state_d = PUTOUT;
            end
            PUTOUT: begin
                single_val_d   = z_q;
                single_ready_d = 1'b1;
                if (single_ready_q && single_cont) begin
                    single_ready_d = 1'b0;
                    state_d        = GETIN;
                end
            end
            default: begin
                state_d = GETIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        state_q        <= state_d;
        a_q            <= a_d;
        a_s_q          <= a_s_d;
        a_m_q          <= a_m_d;
        a_e_q          <= a_e_d;
        z_q            <= z_d;
        single_val_q   <= single_val_d;
        int_ready_q    <= int_ready_d;
        single_ready_q <= single_ready_d;
        // Reset overrides the update above, abandoning any conversion in flight.
        if (rst) begin
            state_q        <= GETIN;
            single_val_q   <= 32'd0;
            int_ready_q    <= 1'b0;
            single_ready_q <= 1'b0;
        end
    end

    assign single_val   = single_val_q;
    assign int_ready    = int_ready_q;
    assign single_ready = single_ready_q;

endmodule

// File: tb/tb_int_to_single_small.sv
// Randomised self-checking bench for int_to_single_small against an arithmetic float model.
// Rounding expectations follow INT_TO_SINGLE_ROUND_EN when it is defined for the build.
module tb_int_to_single_small;

`ifdef INT_TO_SINGLE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] int_val;
    logic        int_cont;
    logic        single_cont;
    logic [31:0] single_val;
    logic        int_ready;
    logic        single_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    int_to_single_small dut (
        .clk          (clk),
        .rst          (rst),
        .int_val      (int_val),
        .int_cont     (int_cont),
        .single_cont  (single_cont),
        .single_val   (single_val),
        .int_ready    (int_ready),
        .single_ready (single_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Float built from the integer's value: find the top set bit, split off the
    // fraction, and round the discarded remainder to nearest-even if enabled.
    function automatic logic [31:0] ref_float(input logic [31:0] v);
        longint m, frac, mant, rem, half, body;
        int     e;
        bit     s, inc;
        if (v == 32'd0) return 32'd0;
        s = v[31];
        m = s ? -longint'($signed(v)) : longint'(v);
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        frac = m - (longint'(1) << e);
        if (e <= 23) begin
            mant = frac << (23 - e);
            rem  = 0;
            half = 1;
        end else begin
            mant = frac >> (e - 23);
            rem  = frac - (mant << (e - 23));
            half = longint'(1) << (e - 24);
        end
        inc  = RND && ((rem > half) || (rem == half && mant[0]));
        body = longint'(e + 127) * 64'd8388608 + mant + longint'(inc);
        return {s, body[30:0]};
    endfunction

    function automatic int lead_zeros(input logic [31:0] v);
        logic [31:0] mag;
        mag = v[31] ? (~v + 32'd1) : v;
        for (int i = 31; i >= 0; i--) if (mag[i]) return 31 - i;
        return 32;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50 && !int_ready; i++) @(negedge clk);
        if (!int_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction; hold > 0 applies that many cycles of backpressure.
    task automatic convert(input logic [31:0] v, input int hold, input bit early, output logic [31:0] got);
        int n;
        logic [31:0] exp;
        exp = ref_float(v);
        got = 32'hxxxxxxxx;
        wait_ready();
        int_val  = v;
        int_cont = 1'b1;
        @(negedge clk);
        int_cont = 1'b0;
        int_val  = $urandom;
        check("ready_drop", {31'd0, int_ready}, 32'd0);
        if (early) single_cont = 1'b1;
        n = 0;
        while (!single_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!single_ready) begin
            check("done_timeout", 32'd0, 32'd1);
            single_cont = 1'b0;
            return;
        end
        got = single_val;
        check("value", single_val, exp);
        if (v != 32'd0) check("latency", n, 5 + lead_zeros(v));
        else            check("zero_latency_le5", {31'd0, (n <= 5)}, 32'd1);
        single_cont = 1'b0;
        for (int i = 0; i < hold; i++) begin
            int_cont = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_val", single_val, exp);
            check("hold_busy", {30'd0, int_ready, single_ready}, 32'd1);
        end
        int_cont    = 1'b0;
        single_cont = 1'b1;
        @(negedge clk);
        single_cont = 1'b0;
        check("ready_fall", {31'd0, single_ready}, 32'd0);
        check("val_held", single_val, exp);
        @(negedge clk);
        check("ready_back", {31'd0, int_ready}, 32'd1);
        $display("[TB] in=%h out=%h exp=%h lat=%0d hold=%0d", v, got, exp, n, hold);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] v;
        bit seen;

        rst = 1'b1; int_val = 32'd0; int_cont = 1'b0; single_cont = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_val", single_val, 32'd0);
        check("rst_flags", {30'd0, int_ready, single_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_int_ready", {31'd0, int_ready}, 32'd1);

        convert(32'd1, 0, 1'b0, r);          check("one", r, 32'h3F800000);
        convert(32'hFFFFFFFF, 0, 1'b1, r);   check("minus_one", r, 32'hBF800000);
        convert(32'd0, 0, 1'b0, r);          check("zero", r, 32'h00000000);
        convert(32'h80000000, 0, 1'b0, r);   check("int_min", r, 32'hCF000000);
        convert(32'h01000003, 0, 1'b0, r);   check("round_a", r, RND ? 32'h4B800002 : 32'h4B800001);
        convert(32'h7FFFFFFF, 0, 1'b0, r);   check("int_max", r, RND ? 32'h4F000000 : 32'h4EFFFFFF);
        convert(32'h00001234, 20, 1'b0, r);  check("backpressure", r, 32'h4591A000);

        // Abort a conversion of 5 while it is still shifting.
        wait_ready();
        int_val = 32'd5; int_cont = 1'b1;
        @(negedge clk);
        int_cont = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_val", single_val, 32'd0);
        check("abort_flags", {30'd0, int_ready, single_ready}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (single_ready) seen = 1'b1;
        end
        check("abort_no_out", {31'd0, seen}, 32'd0);
        $display("[TB] in=00000005 aborted by reset");
        convert(32'd5, 0, 1'b0, r);          check("after_abort", r, 32'h40A00000);

        for (int k = 0; k < 40; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            convert(v, (k % 8 == 0) ? 5 : 0, 1'($urandom_range(0, 1)), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
